ga25_obj_sdr_port: RTL and testbench
====================================

Name: ga25_obj_sdr_port

Overview:
- SDRAM-side responder for the GA25 object engine's fetch port.
- Accepts single-cycle 64-bit bitplane read requests and refresh hints from the object engine.
- Converts each read into a 4-word x 16-bit burst read on the shared SDRAM controller's client port, then assembles the words.
- Returns the assembled 64-bit word with a one-cycle ready pulse. Sits between ga25_obj and the SDRAM controller, entirely in the clk_ram domain.

Parameters:
- TIMEOUT, 64: clk_ram cycles allowed from read issue to the 4th data word before the read is aborted.
- ADDR_W, 25: width of the byte address.

Ports:
- clk_ram  in  1  SDRAM clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- obj_addr  in  25  byte address of the 64-bit fetch; bits [2:0] ignored, treated as 0.
- obj_req  in  1  read request; sampled high for one or more cycles counts as one request per rising edge.
- obj_refresh  in  1  refresh hint; rising edge counts as one request.
- obj_data  out  64  assembled bitplane data.
- obj_rdy  out  1  one-cycle pulse when obj_data is updated.
- obj_err  out  1  sticky; set on timeout or request overrun, cleared by reset.
- mem_addr  out  25  burst start address to the controller.
- mem_rd  out  1  read command; held until mem_ack.
- mem_refresh  out  1  refresh command; held until mem_ack.
- mem_ack  in  1  one-cycle command acceptance.
- mem_dout  in  16  burst data word.
- mem_dvalid  in  1  mem_dout valid strobe.

Behaviour:
- Clock and reset: clk_ram; reset synchronous, active-high.
- Reset values: obj_data=0, obj_rdy=0, obj_err=0, mem_rd=0, mem_refresh=0, mem_addr=0; state IDLE; pending flags cleared; word counter 0; timer 0.
- Reset mid-operation: abandon immediately. Any mem_dvalid or mem_ack arriving afterwards while IDLE is ignored.
- Edge detection: registered copies of obj_req/obj_refresh. A rising edge sets rd_pend (latching obj_addr with [2:0]=0) or ref_pend respectively.
- Both edges in the same cycle set both flags.
- A request edge while rd_pend is already set overwrites the latched address and sets obj_err (overrun).
- States:
  - IDLE: if rd_pend, go to RD_CMD; else if ref_pend, go to REF_CMD. Read wins over refresh.
  - RD_CMD: mem_rd=1, mem_addr=latched address, rd_pend cleared on entry. On mem_ack, drop mem_rd and go to RD_DATA; timer starts at issue.
  - RD_DATA: each mem_dvalid stores mem_dout in lane cnt (cnt=0 -> bits [15:0] ... cnt=3 -> bits [63:48]) and increments cnt (2 bits). The 4th strobe goes to DONE.
  - DONE: obj_data <= assembled word, obj_rdy=1 for exactly one cycle, cnt=0, go to IDLE.
  - REF_CMD: mem_refresh=1, ref_pend cleared on entry. On mem_ack, drop it and go to IDLE.
- Latency: obj_req edge at cycle 0 -> mem_rd=1 at cycle 2 (edge register plus IDLE decision). obj_rdy follows 1 cycle after the cycle that carries the 4th mem_dvalid.
- Timeout: timer counts every cycle in RD_CMD/RD_DATA. On reaching TIMEOUT-1:
  - obj_data <= 0, obj_rdy pulses, obj_err set;
  - mem_rd dropped, go to IDLE.
  - Late dvalids are then ignored.
- mem_dvalid while in RD_CMD (before ack): ignored.
- obj_data holds its value between obj_rdy pulses.
- New request/refresh edges arriving during any non-IDLE state are captured and served afterwards.
- Timer and cnt widths: $clog2(TIMEOUT) and 2 bits; no wrap beyond defined range.

Test Plan:
- Basic read: obj_addr=0x0123458, obj_req pulse; ack 2 cycles after mem_rd; dvalid words 0x1111,0x2222,0x3333,0x4444 -> mem_addr=0x0123458, obj_data=0x4444_3333_2222_1111, one obj_rdy pulse, obj_err=0.
- Refresh: obj_refresh pulse while idle -> mem_refresh asserted 2 cycles later, held until mem_ack, then cleared; no obj_rdy.
- Simultaneous: obj_req and obj_refresh in same cycle -> read completes first (obj_rdy), then mem_refresh issued; address unchanged.
- Overrun: second obj_req edge with addr 0x40 before first read starts -> obj_err=1, only one read issued, at 0x40.
- Timeout: ack but only 2 dvalids, TIMEOUT=64 -> obj_rdy pulses with obj_data=0, obj_err=1, state IDLE; late dvalids change nothing.
- Reset mid-burst: reset after 2nd dvalid -> all outputs 0 next cycle; subsequent read of 0x80 returns correct data.

Source files
------------

// File: rtl/ga25_obj_sdr_port.sv
// ---------------------------------------------------------------------------
// ga25_obj_sdr_port
//
// Connects the GA25 object engine's fetch port to one client port of the
// shared SDRAM controller. Each 64-bit bitplane fetch becomes a 4 x 16-bit
// burst read. The four words are assembled and returned with a one-cycle
// ready pulse. Refresh hints from the object engine are forwarded as refresh
// commands. Everything runs on clk_ram.
//
// Ports
//   clk_ram      SDRAM clock; all logic uses its rising edge
//   reset        synchronous, active-high
//   obj_addr     byte address of the fetch; bits [2:0] are forced to 0
//   obj_req      read request; each rising edge is one request
//   obj_refresh  refresh hint; each rising edge is one request
//   obj_data     assembled 64-bit word; held between obj_rdy pulses
//   obj_rdy      one-cycle pulse when obj_data is updated
//   obj_err      sticky flag for timeout or request overrun
//   mem_addr     burst start address to the controller
//   mem_rd       read command; held until mem_ack
//   mem_refresh  refresh command; held until mem_ack
//   mem_ack      one-cycle command acceptance from the controller
//   mem_dout     burst data word
//   mem_dvalid   mem_dout valid strobe
// ---------------------------------------------------------------------------
module ga25_obj_sdr_port #(
   parameter int TIMEOUT = 64,
   parameter int ADDR_W  = 25
) (
   input  logic              clk_ram,
   input  logic              reset,
   input  logic [ADDR_W-1:0] obj_addr,
   input  logic              obj_req,
   input  logic              obj_refresh,
   output logic [63:0]       obj_data,
   output logic              obj_rdy,
   output logic              obj_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_refresh,
   input  logic              mem_ack,
   input  logic [15:0]       mem_dout,
   input  logic              mem_dvalid
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_DATA,
      DONE,
      REF_CMD
   } state_t;

   state_t            state, state_nx;
   logic              req_q, ref_q;
   logic              req_edge, ref_edge;
   logic              rd_pend, ref_pend;
   logic [ADDR_W-1:0] addr_lat;
   logic [1:0]        cnt;
   logic [TMR_W-1:0]  timer;
   logic [47:0]       lanes;

   // Per-cycle events decoded by the FSM and used by the datapath.
   logic start_rd, start_ref, word_in, last_word, time_out;

   assign req_edge = obj_req & ~req_q;
   assign ref_edge = obj_refresh & ~ref_q;

   always_ff @(posedge clk_ram) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case statement. Without
      // it, any path that skips an assignment would infer a latch.
      state_nx  = state;
      start_rd  = 1'b0;
      start_ref = 1'b0;
      word_in   = 1'b0;
      last_word = 1'b0;
      time_out  = 1'b0;
      case (state)
         IDLE: begin
            // A read takes priority over a refresh.
            if (rd_pend) begin
               start_rd = 1'b1;
               state_nx = RD_CMD;
            end else if (ref_pend) begin
               start_ref = 1'b1;
               state_nx  = REF_CMD;
            end
         end
         RD_CMD: begin
            if (timer == TMR_LAST) begin
               time_out = 1'b1;
               state_nx = IDLE;
            end else if (mem_ack) begin
               state_nx = RD_DATA;
            end
         end
         RD_DATA: begin
            // If the last word arrives in the same cycle as the timeout
            // expires, the completed burst wins.
            if (mem_dvalid && cnt == 2'd3) begin
               last_word = 1'b1;
               state_nx  = DONE;
            end else if (timer == TMR_LAST) begin
               time_out = 1'b1;
               state_nx = IDLE;
            end else begin
               word_in = mem_dvalid;
            end
         end
         DONE:    state_nx = IDLE;
         REF_CMD: if (mem_ack) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_ram) begin
      if (reset) begin
         req_q       <= 1'b0;
         ref_q       <= 1'b0;
         rd_pend     <= 1'b0;
         ref_pend    <= 1'b0;
         addr_lat    <= '0;
         cnt         <= 2'd0;
         timer       <= '0;
         lanes       <= '0;
         obj_data    <= '0;
         obj_rdy     <= 1'b0;
         obj_err     <= 1'b0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         mem_refresh <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only. Every
         // right-hand side therefore sees the values from before this edge.
         req_q   <= obj_req;
         ref_q   <= obj_refresh;
         obj_rdy <= 1'b0;

         // A new request edge takes priority over the pending flag being
         // consumed, so a request that arrives during the issue cycle is not
         // lost. It counts as an overrun only if it replaces an address that
         // has not been issued yet.
         if (req_edge) begin
            rd_pend  <= 1'b1;
            addr_lat <= {obj_addr[ADDR_W-1:3], 3'b000};
            if (rd_pend && !start_rd) obj_err <= 1'b1;
         end else if (start_rd) begin
            rd_pend <= 1'b0;
         end

         if (ref_edge)       ref_pend <= 1'b1;
         else if (start_ref) ref_pend <= 1'b0;

         if (start_rd) begin
            mem_rd   <= 1'b1;
            mem_addr <= addr_lat;
            timer    <= '0;
            cnt      <= 2'd0;
         end else if (state == RD_CMD || state == RD_DATA) begin
            timer <= timer + 1'b1;
         end

         if (state == RD_CMD && mem_ack) mem_rd <= 1'b0;

         if (start_ref)                         mem_refresh <= 1'b1;
         else if (state == REF_CMD && mem_ack)  mem_refresh <= 1'b0;

         if (word_in) begin
            case (cnt)
               2'd0:    lanes[15:0]  <= mem_dout;
               2'd1:    lanes[31:16] <= mem_dout;
               default: lanes[47:32] <= mem_dout;
            endcase
            cnt <= cnt + 2'd1;
         end

         // The last word goes straight into the output, so obj_rdy and the
         // new obj_data appear in the cycle after the 4th strobe.
         if (last_word) begin
            obj_data <= {mem_dout, lanes};
            obj_rdy  <= 1'b1;
         end

         if (state == DONE) cnt <= 2'd0;

         if (time_out) begin
            obj_data <= '0;
            obj_rdy  <= 1'b1;
            obj_err  <= 1'b1;
            mem_rd   <= 1'b0;
            cnt      <= 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_ga25_obj_sdr_port.sv
// ---------------------------------------------------------------------------
// tb_ga25_obj_sdr_port
//
// Directed and random fetches against ga25_obj_sdr_port. The bench acts as
// the SDRAM controller. Expected results are built from the fetch rules:
// the address has its low 3 bits cleared, and the data is the four burst
// words packed with the first word in the lowest lane.
// ---------------------------------------------------------------------------
module tb_ga25_obj_sdr_port;

   localparam int ADDR_W = 25;

   logic              clk_ram = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] obj_addr;
   logic              obj_req, obj_refresh;
   logic [63:0]       obj_data;
   logic              obj_rdy, obj_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd, mem_refresh;
   logic              mem_ack;
   logic [15:0]       mem_dout;
   logic              mem_dvalid;

   int total = 0;
   int bad   = 0;

   ga25_obj_sdr_port #(.TIMEOUT(64), .ADDR_W(ADDR_W)) dut (
      .clk_ram     (clk_ram),
      .reset       (reset),
      .obj_addr    (obj_addr),
      .obj_req     (obj_req),
      .obj_refresh (obj_refresh),
      .obj_data    (obj_data),
      .obj_rdy     (obj_rdy),
      .obj_err     (obj_err),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_refresh (mem_refresh),
      .mem_ack     (mem_ack),
      .mem_dout    (mem_dout),
      .mem_dvalid  (mem_dvalid)
   );

   always #5 clk_ram = ~clk_ram;

   // Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk_ram);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_req(input logic [ADDR_W-1:0] a);
      obj_addr = a;
      obj_req  = 1'b1;
      tick();
      obj_req  = 1'b0;
   endtask

   task automatic pulse_ref();
      obj_refresh = 1'b1;
      tick();
      obj_refresh = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      mem_dout   = w;
      mem_dvalid = 1'b1;
      tick();
      mem_dvalid = 1'b0;
   endtask

   task automatic wait_rd();
      int n = 0;
      while (!mem_rd && n < 20) begin
         tick();
         n++;
      end
      check("wait_mem_rd", mem_rd, 1);
   endtask

   // Controller side of a complete read: accept the command after ack_dly
   // cycles, then return the four words with random gaps between them.
   task automatic serve_read(input string tag, input logic [ADDR_W-1:0] exp_addr,
                             input logic [63:0] exp_data, input int ack_dly,
                             input int max_gap);
      wait_rd();
      check({tag, "_addr"}, mem_addr, exp_addr);
      for (int i = 0; i < ack_dly; i++) begin
         tick();
         check({tag, "_rd_held"}, mem_rd, 1);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check({tag, "_rd_drop"}, mem_rd, 0);
      for (int i = 0; i < 4; i++) begin
         int gap = $urandom_range(max_gap, 0);
         for (int g = 0; g < gap; g++) tick();
         send_word(exp_data[16*i +: 16]);
         if (i < 3) check({tag, "_no_early_rdy"}, obj_rdy, 0);
      end
      check({tag, "_rdy"}, obj_rdy, 1);
      check({tag, "_data"}, obj_data, exp_data);
      tick();
      check({tag, "_rdy_pulse"}, obj_rdy, 0);
      check({tag, "_data_hold"}, obj_data, exp_data);
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      logic [63:0]       d;
      logic [63:0]       last_data;
      int                n;

      reset = 1'b1; obj_addr = '0; obj_req = 1'b0; obj_refresh = 1'b0;
      mem_ack = 1'b0; mem_dout = '0; mem_dvalid = 1'b0;
      repeat (3) tick();
      check("rst_data", obj_data, 0);
      check("rst_rdy",  obj_rdy, 0);
      check("rst_err",  obj_err, 0);
      check("rst_rd",   mem_rd, 0);
      check("rst_ref",  mem_refresh, 0);
      check("rst_addr", mem_addr, 0);
      reset = 1'b0;
      tick();

      // Basic read with a 2-cycle command latency check.
      pulse_req(25'h0123458);
      check("basic_rd_early", mem_rd, 0);
      tick();
      check("basic_rd_latency", mem_rd, 1);
      serve_read("basic", 25'h0123458, 64'h4444_3333_2222_1111, 2, 0);
      check("basic_err", obj_err, 0);

      // Refresh while idle.
      pulse_ref();
      check("ref_early", mem_refresh, 0);
      tick();
      check("ref_latency", mem_refresh, 1);
      repeat (2) tick();
      check("ref_held", mem_refresh, 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("ref_drop", mem_refresh, 0);
      check("ref_no_rdy", obj_rdy, 0);
      tick();
      check("ref_no_rd", mem_rd, 0);

      // A simultaneous read and refresh: the read is served first.
      obj_addr = 25'h0ABCDEF; obj_req = 1'b1; obj_refresh = 1'b1;
      tick();
      obj_req = 1'b0; obj_refresh = 1'b0;
      tick();
      check("simul_rd_first", mem_rd, 1);
      check("simul_ref_wait", mem_refresh, 0);
      serve_read("simul", 25'h0ABCDE8, 64'hDEAD_BEEF_0123_4567, 1, 1);
      n = 0;
      while (!mem_refresh && n < 10) begin tick(); n++; end
      check("simul_ref_issued", mem_refresh, 1);
      check("simul_addr_kept", mem_addr, 25'h0ABCDE8);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      check("simul_ref_drop", mem_refresh, 0);

      // Random reads against the packing model.
      for (int k = 0; k < 6; k++) begin
         a = ADDR_W'($urandom);
         d = {$urandom, $urandom};
         pulse_req(a);
         serve_read("rand", a & ~ADDR_W'(7), d, $urandom_range(3, 0), 2);
         tick();
      end
      check("rand_err", obj_err, 0);

      // Overrun: two request edges while a refresh keeps the port busy.
      pulse_ref();
      tick();
      check("ovr_ref_busy", mem_refresh, 1);
      pulse_req(25'h0000100);
      tick();
      check("ovr_no_err_yet", obj_err, 0);
      pulse_req(25'h0000047);
      check("ovr_err", obj_err, 1);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      serve_read("ovr", 25'h0000040, 64'h0102_0304_0506_0708, 0, 0);
      last_data = 64'h0102_0304_0506_0708;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ovr_single_read", mem_rd, 0);
      end

      // Timeout: acknowledged, but only 2 of the 4 words arrive.
      pulse_req(25'h0000200);
      wait_rd();
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      send_word(16'hAAAA);
      send_word(16'hBBBB);
      n = 0;
      while (!obj_rdy && n < 80) begin
         check("to_no_early_rdy", obj_data, last_data);
         tick();
         n++;
      end
      check("to_rdy", obj_rdy, 1);
      check("to_data_zero", obj_data, 0);
      check("to_err", obj_err, 1);
      check("to_rd_low", mem_rd, 0);
      tick();
      check("to_rdy_pulse", obj_rdy, 0);
      send_word(16'hCCCC);
      send_word(16'hDDDD);
      tick();
      check("to_late_rdy", obj_rdy, 0);
      check("to_late_data", obj_data, 0);
      check("to_late_rd", mem_rd, 0);

      // Reset in the middle of a burst, then a clean read.
      pulse_req(25'h0000300);
      wait_rd();
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      send_word(16'h1234);
      send_word(16'h5678);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_data", obj_data, 0);
      check("mid_rst_err",  obj_err, 0);
      check("mid_rst_rd",   mem_rd, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_rdy",  obj_rdy, 0);
      mem_ack = 1'b1; send_word(16'h9ABC); mem_ack = 1'b0;
      send_word(16'hDEF0);
      tick();
      check("mid_rst_ignore_rdy", obj_rdy, 0);
      check("mid_rst_ignore_rd",  mem_rd, 0);
      pulse_req(25'h0000080);
      serve_read("post_rst", 25'h0000080, 64'hCAFE_F00D_8765_4321, 2, 1);
      check("post_rst_err", obj_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
